// File: rtl/dual_spi_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dual_spi_slave_ctrl
// Brief    : Dual-data-pin SPI slave bridging host write/read bursts to a
//            byte-wide fabric interface.
// Revision : 1.0 - initial release
// ============================================================================
module dual_spi_slave_ctrl #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CMD_WRITE   = 8'h01,
    parameter logic [7:0] CMD_READ    = 8'h02
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       io_ss,
    input  logic       io_sclk,
    input  logic [1:0] io_qd_read,
    output logic [1:0] io_qd_write,
    output logic [1:0] io_qd_writeEnable,
    output logic [7:0] io_wr_data,
    output logic       io_wr_valid,
    input  logic [7:0] io_rd_data,
    input  logic       io_rd_valid,
    output logic       io_rd_ready,
    output logic       io_busy,
    output logic       io_cmd_err,
    output logic       io_underflow
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_cmd    = 3'd1;
    localparam logic [2:0] c_st_write  = 3'd2;
    localparam logic [2:0] c_st_turn   = 3'd3;
    localparam logic [2:0] c_st_read   = 3'd4;
    localparam logic [2:0] c_st_ignore = 3'd5;

    logic [SYNC_STAGES-1:0]      r_ss_sync;
    logic [SYNC_STAGES-1:0]      r_sclk_sync;
    logic [SYNC_STAGES-1:0][1:0] r_qd_sync;
    logic                        r_ss_prev;
    logic                        r_sclk_prev;

    logic [2:0] r_state;
    logic [2:0] w_state_next;
    logic [1:0] r_pair_cnt;
    logic [5:0] r_rx_shift;
    logic [5:0] r_tx_shift;
    logic [1:0] r_qd_write;
    logic [1:0] r_qd_oe;
    logic [7:0] r_wr_data;
    logic       r_wr_valid;
    logic       r_rd_ready;
    logic       r_cmd_err;
    logic       r_underflow;

    logic       w_ss;
    logic       w_sclk;
    logic [1:0] w_qd;
    logic       w_ss_fall;
    logic       w_ss_rise;
    logic       w_sclk_rise;
    logic       w_sclk_fall;
    logic [7:0] w_rx_byte;
    logic       w_byte_done;
    logic [7:0] w_tx_byte;

    // All three inputs share one chain length so data stays aligned to sclk.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ss_sync   <= '0;
            r_sclk_sync <= '0;
            r_qd_sync   <= '0;
        end else begin
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], io_ss};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], io_sclk};
            r_qd_sync   <= {r_qd_sync[SYNC_STAGES-2:0], io_qd_read};
        end
    end

    assign w_ss        = r_ss_sync[SYNC_STAGES-1];
    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_qd        = r_qd_sync[SYNC_STAGES-1];
    assign w_ss_fall   = r_ss_prev & ~w_ss;
    assign w_ss_rise   = ~r_ss_prev & w_ss;
    assign w_sclk_rise = ~r_sclk_prev & w_sclk;
    assign w_sclk_fall = r_sclk_prev & ~w_sclk;
    assign w_rx_byte   = {r_rx_shift, w_qd};
    assign w_byte_done = w_sclk_rise && (r_pair_cnt == 2'd3);
    assign w_tx_byte   = io_rd_valid ? io_rd_data : 8'h00;

    always_comb begin
        w_state_next = r_state;
        if (r_state == c_st_idle) begin
            if (w_ss_fall) begin
                w_state_next = c_st_cmd;
            end
        end else if (w_ss_rise) begin
            w_state_next = c_st_idle;
        end else begin
            case (r_state)
                c_st_cmd: begin
                    if (w_byte_done) begin
                        if (w_rx_byte == CMD_WRITE) begin
                            w_state_next = c_st_write;
                        end else if (w_rx_byte == CMD_READ) begin
                            w_state_next = c_st_turn;
                        end else begin
                            w_state_next = c_st_ignore;
                        end
                    end
                end
                c_st_turn: begin
                    if (w_byte_done) begin
                        w_state_next = c_st_read;
                    end
                end
                c_st_write, c_st_read, c_st_ignore: w_state_next = r_state;
                default: w_state_next = c_st_idle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_ss_prev   <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_pair_cnt  <= 2'd0;
            r_rx_shift  <= 6'd0;
            r_tx_shift  <= 6'd0;
            r_qd_write  <= 2'b00;
            r_qd_oe     <= 2'b00;
            r_wr_data   <= 8'h00;
            r_wr_valid  <= 1'b0;
            r_rd_ready  <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ss_prev   <= w_ss;
            r_sclk_prev <= w_sclk;
            r_wr_valid  <= 1'b0;
            r_rd_ready  <= 1'b0;
            r_cmd_err   <= 1'b0;
            if (r_state == c_st_idle) begin
                if (w_ss_fall) begin
                    r_pair_cnt  <= 2'd0;
                    r_rx_shift  <= 6'd0;
                    r_underflow <= 1'b0;
                end
            end else if (w_ss_rise) begin
                // Frame end: partial bytes are dropped, pins released.
                r_pair_cnt <= 2'd0;
                r_qd_oe    <= 2'b00;
                r_qd_write <= 2'b00;
            end else begin
                case (r_state)
                    c_st_cmd, c_st_write, c_st_turn: begin
                        if (w_sclk_rise) begin
                            r_rx_shift <= w_rx_byte[5:0];
                            r_pair_cnt <= r_pair_cnt + 2'd1;
                        end
                        if (w_byte_done && (r_state == c_st_cmd)) begin
                            r_cmd_err <= (w_rx_byte != CMD_WRITE) && (w_rx_byte != CMD_READ);
                        end
                        if (w_byte_done && (r_state == c_st_write)) begin
                            r_wr_data  <= w_rx_byte;
                            r_wr_valid <= 1'b1;
                        end
                    end
                    c_st_read: begin
                        if (w_sclk_fall) begin
                            r_qd_oe    <= 2'b11;
                            r_pair_cnt <= r_pair_cnt + 2'd1;
                            if (r_pair_cnt == 2'd0) begin
                                r_qd_write <= w_tx_byte[7:6];
                                r_tx_shift <= w_tx_byte[5:0];
                                r_rd_ready <= io_rd_valid;
                                if (!io_rd_valid) begin
                                    r_underflow <= 1'b1;
                                end
                            end else begin
                                r_qd_write <= r_tx_shift[5:4];
                                r_tx_shift <= {r_tx_shift[3:0], 2'b00};
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign io_qd_write       = r_qd_write;
    assign io_qd_writeEnable = r_qd_oe;
    assign io_wr_data        = r_wr_data;
    assign io_wr_valid       = r_wr_valid;
    assign io_rd_ready       = r_rd_ready;
    assign io_busy           = (r_state != c_st_idle);
    assign io_cmd_err        = r_cmd_err;
    assign io_underflow      = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_dual_spi_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_spi_slave_ctrl
// Brief    : Scoreboard bench driving host frames into dual_spi_slave_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_spi_slave_ctrl;

    localparam int c_sync = 2;
    localparam int c_half = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       io_ss;
    logic       io_sclk;
    logic [1:0] io_qd_read;
    logic [1:0] io_qd_write;
    logic [1:0] io_qd_writeEnable;
    logic [7:0] io_wr_data;
    logic       io_wr_valid;
    logic [7:0] io_rd_data;
    logic       io_rd_valid;
    logic       io_rd_ready;
    logic       io_busy;
    logic       io_cmd_err;
    logic       io_underflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] obs_wr[$];
    int         obs_rd = 0;
    logic [7:0] exp_wr[$];
    logic [7:0] exp_rd[$];
    int         rd_ready_cnt = 0;
    int         cmd_err_cnt  = 0;
    int         wr_long      = 0;
    int         busy_drops   = 0;
    logic       busy_watch   = 1'b0;
    logic       prev_wr_valid = 1'b0;
    logic [1:0] last_oe;

    logic [7:0] src_mem [4];
    int         src_base = 0;
    int         src_len  = 0;
    int         src_idx;

    assign src_idx     = rd_ready_cnt - src_base;
    assign io_rd_valid = (src_idx < src_len);
    assign io_rd_data  = src_mem[src_idx & 3];

    always #5 clk = ~clk;

    dual_spi_slave_ctrl #(.SYNC_STAGES(c_sync), .CMD_WRITE(8'h01), .CMD_READ(8'h02)) dut (
        .clk(clk), .reset(reset), .io_ss(io_ss), .io_sclk(io_sclk),
        .io_qd_read(io_qd_read), .io_qd_write(io_qd_write),
        .io_qd_writeEnable(io_qd_writeEnable), .io_wr_data(io_wr_data),
        .io_wr_valid(io_wr_valid), .io_rd_data(io_rd_data),
        .io_rd_valid(io_rd_valid), .io_rd_ready(io_rd_ready),
        .io_busy(io_busy), .io_cmd_err(io_cmd_err), .io_underflow(io_underflow)
    );

    always @(negedge clk) begin
        if (io_wr_valid) obs_wr.push_back(io_wr_data);
        if (io_wr_valid && prev_wr_valid) wr_long++;
        prev_wr_valid = io_wr_valid;
        if (io_rd_ready) rd_ready_cnt++;
        if (io_cmd_err) cmd_err_cnt++;
        if (busy_watch && !io_busy) busy_drops++;
    end

    task automatic spi_pair(input logic [1:0] tx, output logic [1:0] rx);
        @(negedge clk);
        io_sclk    = 1'b0;
        io_qd_read = tx;
        repeat (c_half) @(negedge clk);
        rx      = io_qd_write;
        last_oe = io_qd_writeEnable;
        io_sclk = 1'b1;
        repeat (c_half) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic [1:0] p;
        rx = 8'h00;
        for (int i = 0; i < 4; i++) begin
            spi_pair(tx[7-2*i -: 2], p);
            rx = {rx[5:0], p};
        end
    endtask

    task automatic frame_start();
        @(negedge clk);
        io_ss = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic frame_end();
        @(negedge clk);
        io_ss = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; io_ss = 1'b1; io_sclk = 1'b0; io_qd_read = 2'b00;
        repeat (4) @(negedge clk);
        n_cmp++; if (io_qd_writeEnable !== 2'b00) begin n_err++; $display("FAIL rst_oe: got %0h expected 0", io_qd_writeEnable); end
        n_cmp++; if (io_qd_write !== 2'b00) begin n_err++; $display("FAIL rst_qd: got %0h expected 0", io_qd_write); end
        n_cmp++; if (io_wr_valid !== 1'b0) begin n_err++; $display("FAIL rst_wr_valid: got %0b expected 0", io_wr_valid); end
        n_cmp++; if (io_rd_ready !== 1'b0) begin n_err++; $display("FAIL rst_rd_ready: got %0b expected 0", io_rd_ready); end
        n_cmp++; if (io_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b expected 0", io_busy); end
        n_cmp++; if (io_cmd_err !== 1'b0) begin n_err++; $display("FAIL rst_cmd_err: got %0b expected 0", io_cmd_err); end
        n_cmp++; if (io_underflow !== 1'b0) begin n_err++; $display("FAIL rst_underflow: got %0b expected 0", io_underflow); end
        n_cmp++; if (io_wr_data !== 8'h00) begin n_err++; $display("FAIL rst_wr_data: got %0h expected 0", io_wr_data); end
        reset = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_write();
        logic [7:0] rx;
        int         base_long;
        int         base_drop;
        base_long = wr_long;
        base_drop = busy_drops;
        frame_start();
        busy_watch = 1'b1;
        spi_byte(8'h01, rx);
        exp_wr.push_back(8'hA5); spi_byte(8'hA5, rx);
        exp_wr.push_back(8'h3C); spi_byte(8'h3C, rx);
        repeat (4) @(negedge clk);
        busy_watch = 1'b0;
        frame_end();
        n_cmp++; if (obs_wr.size() - obs_rd != exp_wr.size()) begin n_err++; $display("FAIL wr_count: got %0d expected %0d", obs_wr.size() - obs_rd, exp_wr.size()); end
        while (exp_wr.size() > 0 && obs_rd < obs_wr.size()) begin
            n_cmp++; if (obs_wr[obs_rd] !== exp_wr[0]) begin n_err++; $display("FAIL wr_data: got %0h expected %0h", obs_wr[obs_rd], exp_wr[0]); end
            void'(exp_wr.pop_front()); obs_rd++;
        end
        exp_wr.delete(); obs_rd = obs_wr.size();
        n_cmp++; if (busy_drops != base_drop) begin n_err++; $display("FAIL wr_busy: got %0d drops expected 0", busy_drops - base_drop); end
        n_cmp++; if (wr_long != base_long) begin n_err++; $display("FAIL wr_pulse_width: got %0d long expected 0", wr_long - base_long); end
    endtask

    task automatic test_read();
        logic [7:0] rx;
        int         base_rdy;
        src_mem[0] = 8'h96; src_mem[1] = 8'h0F;
        src_base = rd_ready_cnt; src_len = 2; base_rdy = rd_ready_cnt;
        exp_rd.push_back(8'h96); exp_rd.push_back(8'h0F);
        frame_start();
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        for (int b = 0; b < 2; b++) begin
            spi_byte(8'h00, rx);
            n_cmp++; if (rx !== exp_rd[0]) begin n_err++; $display("FAIL rd_byte%0d: got %0h expected %0h", b, rx, exp_rd[0]); end
            void'(exp_rd.pop_front());
        end
        n_cmp++; if (last_oe !== 2'b11) begin n_err++; $display("FAIL rd_oe: got %0h expected 3", last_oe); end
        frame_end();
        n_cmp++; if (rd_ready_cnt - base_rdy != 2) begin n_err++; $display("FAIL rd_ready_count: got %0d expected 2", rd_ready_cnt - base_rdy); end
        n_cmp++; if (io_underflow !== 1'b0) begin n_err++; $display("FAIL rd_underflow: got %0b expected 0", io_underflow); end
        n_cmp++; if (io_qd_writeEnable !== 2'b00) begin n_err++; $display("FAIL rd_oe_after: got %0h expected 0", io_qd_writeEnable); end
    endtask

    task automatic test_underflow();
        logic [7:0] rx;
        int         base_rdy;
        src_base = rd_ready_cnt; src_len = 0; base_rdy = rd_ready_cnt;
        frame_start();
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        n_cmp++; if (rx !== 8'h00) begin n_err++; $display("FAIL uf_byte: got %0h expected 0", rx); end
        frame_end();
        n_cmp++; if (rd_ready_cnt != base_rdy) begin n_err++; $display("FAIL uf_rd_ready: got %0d expected 0", rd_ready_cnt - base_rdy); end
        n_cmp++; if (io_underflow !== 1'b1) begin n_err++; $display("FAIL uf_sticky: got %0b expected 1", io_underflow); end
        frame_start();
        n_cmp++; if (io_underflow !== 1'b0) begin n_err++; $display("FAIL uf_clear: got %0b expected 0", io_underflow); end
        frame_end();
    endtask

    task automatic test_bad_cmd();
        logic [7:0] rx;
        int         base_err;
        int         base_rdy;
        base_err = cmd_err_cnt; base_rdy = rd_ready_cnt;
        src_base = rd_ready_cnt; src_len = 0;
        frame_start();
        spi_byte(8'h7E, rx);
        spi_byte(8'hFF, rx);
        spi_byte(8'h01, rx);
        n_cmp++; if (io_busy !== 1'b1) begin n_err++; $display("FAIL bad_busy: got %0b expected 1", io_busy); end
        n_cmp++; if (last_oe !== 2'b00) begin n_err++; $display("FAIL bad_oe: got %0h expected 0", last_oe); end
        frame_end();
        n_cmp++; if (cmd_err_cnt - base_err != 1) begin n_err++; $display("FAIL bad_cmd_err: got %0d expected 1", cmd_err_cnt - base_err); end
        n_cmp++; if (obs_wr.size() - obs_rd != 0 || rd_ready_cnt != base_rdy) begin n_err++; $display("FAIL bad_strobes: got %0d expected 0", obs_wr.size() - obs_rd + rd_ready_cnt - base_rdy); end
        obs_rd = obs_wr.size();
    endtask

    task automatic test_abort();
        logic [7:0] rx;
        logic [1:0] p;
        frame_start();
        spi_byte(8'h01, rx);
        spi_pair(2'b11, p);
        @(negedge clk);
        io_ss = 1'b1;
        repeat (c_sync + 2) @(posedge clk);
        #1;
        n_cmp++; if (io_busy !== 1'b0) begin n_err++; $display("FAIL abort_idle: got %0b expected 0", io_busy); end
        repeat (8) @(negedge clk);
        n_cmp++; if (obs_wr.size() - obs_rd != 0) begin n_err++; $display("FAIL abort_no_strobe: got %0d expected 0", obs_wr.size() - obs_rd); end
        obs_rd = obs_wr.size();
        frame_start();
        spi_byte(8'h01, rx);
        exp_wr.push_back(8'h55); spi_byte(8'h55, rx);
        frame_end();
        n_cmp++; if (obs_wr.size() - obs_rd != exp_wr.size()) begin n_err++; $display("FAIL abort_next_count: got %0d expected %0d", obs_wr.size() - obs_rd, exp_wr.size()); end
        while (exp_wr.size() > 0 && obs_rd < obs_wr.size()) begin
            n_cmp++; if (obs_wr[obs_rd] !== exp_wr[0]) begin n_err++; $display("FAIL abort_next_data: got %0h expected %0h", obs_wr[obs_rd], exp_wr[0]); end
            void'(exp_wr.pop_front()); obs_rd++;
        end
        exp_wr.delete(); obs_rd = obs_wr.size();
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] rx;
        logic [1:0] p;
        int         base_rdy;
        src_mem[0] = 8'hC3; src_mem[1] = 8'h5A; src_mem[2] = 8'h11; src_mem[3] = 8'h22;
        src_base = rd_ready_cnt; src_len = 4;
        frame_start();
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_pair(2'b00, p);
        spi_pair(2'b00, p);
        n_cmp++; if (last_oe !== 2'b11) begin n_err++; $display("FAIL rr_oe_before: got %0h expected 3", last_oe); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (io_qd_writeEnable !== 2'b00) begin n_err++; $display("FAIL rr_oe_next: got %0h expected 0", io_qd_writeEnable); end
        @(negedge clk);
        reset = 1'b0;
        base_rdy = rd_ready_cnt;
        for (int i = 0; i < 6; i++) spi_pair(2'b01, p);
        n_cmp++; if (io_busy !== 1'b0) begin n_err++; $display("FAIL rr_busy_ss_low: got %0b expected 0", io_busy); end
        n_cmp++; if (last_oe !== 2'b00) begin n_err++; $display("FAIL rr_oe_ss_low: got %0h expected 0", last_oe); end
        n_cmp++; if (rd_ready_cnt != base_rdy || obs_wr.size() != obs_rd) begin n_err++; $display("FAIL rr_no_activity: got %0d strobes expected 0", rd_ready_cnt - base_rdy + obs_wr.size() - obs_rd); end
        frame_end();
        frame_start();
        spi_byte(8'h01, rx);
        spi_byte(8'h55, rx);
        frame_end();
        n_cmp++; if (obs_wr.size() - obs_rd != 1) begin n_err++; $display("FAIL rr_recover_count: got %0d expected 1", obs_wr.size() - obs_rd); end
        else begin
            n_cmp++; if (obs_wr[obs_rd] !== 8'h55) begin n_err++; $display("FAIL rr_recover_data: got %0h expected 55", obs_wr[obs_rd]); end
        end
        obs_rd = obs_wr.size();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_underflow();
        test_bad_cmd();
        test_abort();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dual_spi_slave_ctrl.md
DUAL_SPI_SLAVE_CTRL -- requirements
Module: dual_spi_slave_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of synchroniser flops on io_ss, io_sclk and io_qd_read (minimum 2).
REQ-002 SHALL have parameter CMD_WRITE, default 8'h01, the command byte opening a host-to-fabric burst.
REQ-003 SHALL have parameter CMD_READ, default 8'h02, the command byte opening a fabric-to-host burst.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port io_ss, input, 1 bit: asynchronous chip select from the host, active low.
REQ-007 SHALL have port io_sclk, input, 1 bit: asynchronous serial clock from the host.
REQ-008 SHALL have port io_qd_read, input, 2 bits: values sampled from the dual data pins.
REQ-009 SHALL have port io_qd_write, output, 2 bits: values driven onto the dual data pins.
REQ-010 SHALL have port io_qd_writeEnable, output, 2 bits: per-pin output enable.
REQ-011 SHALL have port io_wr_data, output, 8 bits: received byte.
REQ-012 SHALL have port io_wr_valid, output, 1 bit: one-cycle strobe qualifying io_wr_data.
REQ-013 SHALL have port io_rd_data, input, 8 bits: byte to transmit.
REQ-014 SHALL have port io_rd_valid, input, 1 bit: io_rd_data is available.
REQ-015 SHALL have port io_rd_ready, output, 1 bit: one-cycle pop strobe consuming io_rd_data.
REQ-016 SHALL have outputs io_busy, io_cmd_err and io_underflow, 1 bit each, carrying the status defined under Function.

Function
REQ-017 SHALL synchronise io_ss, io_sclk and io_qd_read through SYNC_STAGES flops each, so all three see equal delay.
REQ-018 SHALL detect an sclk rise as a synchronised sclk of 1 whose previous value was 0, and an sclk fall as the inverse; each edge is acted on in the same clk cycle it is detected.
REQ-019 SHALL implement the states IDLE, CMD, WRITE, TURN, READ and IGNORE.
REQ-020 SHALL go from IDLE to CMD on a synchronised ss falling edge, clearing the pair counter and io_underflow.
REQ-021 SHALL, on each sclk rise in CMD or WRITE, shift in qd[1:0] MSB-first (qd[1] is the higher bit of each pair), so 4 rises complete a byte.
REQ-022 SHALL decode a completed command byte: CMD_WRITE goes to WRITE, CMD_READ goes to TURN, and any other value goes to IGNORE with a 1-cycle io_cmd_err pulse.
REQ-023 SHALL, in WRITE, present each completed byte on io_wr_data with io_wr_valid=1 for exactly one cycle, in the cycle after the 4th rise; io_wr_data holds its value until the next strobe; there is no backpressure.
REQ-024 SHALL, in TURN, ignore the data on 4 sclk rises (one dummy byte) and then go to READ.
REQ-025 SHALL, on the first sclk fall in READ, set io_qd_writeEnable=2'b11, load a byte and drive its bits [7:6].
REQ-026 SHALL, on each later fall, shift to the next pair ([5:4], [3:2], [1:0]); after [1:0] has been driven, the next fall loads a new byte. Output changes only on falls.
REQ-027 SHALL, on a byte load with io_rd_valid=1, take io_rd_data and pulse io_rd_ready for 1 cycle.
REQ-028 SHALL, on a byte load with io_rd_valid=0, load 8'h00, leave io_rd_ready at 0, and set io_underflow sticky until the next ss falling edge.
REQ-029 SHALL, on a synchronised ss rise in any state, enter IDLE the next cycle, discard any partial byte, set io_qd_writeEnable=0, and issue no strobe.
REQ-030 SHALL drive io_qd_writeEnable=0 in every state except READ.
REQ-031 SHALL drive io_busy=1 whenever the state is not IDLE.
REQ-032 SHALL, in IGNORE, stay there until ss rises, with outputs disabled and no strobes.
REQ-033 SHALL give an ss falling edge precedence in IDLE only; an sclk edge in the same cycle as an ss rise is ignored.

Reset
REQ-034 SHALL, while reset=1 at a clk edge, enter IDLE, clear all synchronisers, shift registers and counters, and drive io_qd_writeEnable=0, io_qd_write=0, io_wr_valid=0, io_rd_ready=0, io_busy=0, io_cmd_err=0, io_underflow=0 and io_wr_data=0.
REQ-035 SHALL, on reset asserted mid-transaction, abort immediately and stay in IDLE after release until a fresh ss falling edge, even if io_ss is already low.

Verification
REQ-036 SHALL pass this scenario: write burst of 0x01, 0xA5, 0x3C -> two io_wr_valid pulses carrying 0xA5 then 0x3C, with io_busy=1 throughout.
REQ-037 SHALL pass this scenario: read burst of 0x02, a dummy byte and 2 bytes with the source holding 0x96 and 0x0F -> pins show pairs 2,1,1,2 then 0,0,3,3; two io_rd_ready pulses; io_underflow=0.
REQ-038 SHALL pass this scenario: read with io_rd_valid=0 -> host receives 0x00, io_rd_ready never asserts, io_underflow=1, and io_underflow clears on the next ss falling edge.
REQ-039 SHALL pass this scenario: command 0x7E -> one io_cmd_err pulse and no strobes for the rest of the frame.
REQ-040 SHALL pass this scenario: ss rises after 2 bits of a write data byte -> no io_wr_valid pulse, IDLE within SYNC_STAGES+2 cycles, and a following 0x01, 0x55 frame delivers exactly 0x55.
REQ-041 SHALL pass this scenario: reset pulsed during READ -> io_qd_writeEnable=0 the next cycle, and no activity until ss is deasserted and then reasserted.
